// File: rtl/unpacked_vector_serializer.sv
// -----------------------------------------------------------------------------
// unpacked_vector_serializer
//
// Captures one wide unpacked vector of IN_NUM elements and replays it as
// BEATS = IN_NUM/OUT_NUM narrower beats of OUT_NUM elements, lowest-index
// slice first. A new vector can be taken on the handshake of the final beat,
// so back-to-back vectors stream with no idle cycle in between.
//
// Parameters
//   DATA_WIDTH : element width in bits
//   IN_NUM     : elements per input vector
//   OUT_NUM    : elements per output beat (must divide IN_NUM)
//
// Ports
//   clk            : clock, rising edge
//   rst            : asynchronous reset, active low
//   data_in        : input vector, DATA_WIDTH x [IN_NUM-1:0] unpacked
//   data_in_valid  : input vector valid
//   data_in_ready  : vector accepted this cycle when high with valid
//   data_out       : current beat, DATA_WIDTH x [OUT_NUM-1:0] unpacked
//   data_out_valid : beat valid
//   data_out_ready : downstream accepts the beat
//   data_out_last  : final beat of a vector (only with SERIALIZER_LAST_EN)
//
// Optional feature macro: SERIALIZER_LAST_EN adds the data_out_last port.
// -----------------------------------------------------------------------------
module unpacked_vector_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_NUM     = 16,
    parameter int OUT_NUM    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in [IN_NUM-1:0],
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out [OUT_NUM-1:0],
    output logic                  data_out_valid,
    input  logic                  data_out_ready
`ifdef SERIALIZER_LAST_EN
    ,
    output logic                  data_out_last
`else
    // no last-beat marker: downstream counts beats itself
`endif
);

    localparam int BEATS = IN_NUM / OUT_NUM;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    // Reject configurations that would leave a partial final beat.
    generate
        if ((IN_NUM % OUT_NUM) != 0) begin : g_bad_cfg
            $error("unpacked_vector_serializer: IN_NUM must be a multiple of OUT_NUM");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [DATA_WIDTH-1:0] vec_q [IN_NUM-1:0];
    logic [DATA_WIDTH-1:0] vec_d [IN_NUM-1:0];
    logic                  last_beat_s;
    logic                  out_fire_s;

    assign last_beat_s = (state_q == ST_BUSY) && (cnt_q == CNT_LAST);
    assign out_fire_s  = (state_q == ST_BUSY) && data_out_ready;

    // Upstream readiness: idle, or the final beat is leaving this cycle.
    // Held low while reset is asserted so nothing is offered as accepted.
    assign data_in_ready = rst && ((state_q == ST_IDLE) || (last_beat_s && data_out_ready));
    assign data_out_valid = (state_q == ST_BUSY);

`ifdef SERIALIZER_LAST_EN
    assign data_out_last = last_beat_s;
`else
`endif

    // Next-state, beat counter and vector-load decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        case (state_q)
            ST_IDLE: begin
                if (data_in_valid) begin
                    vec_d   = data_in;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (out_fire_s) begin
                    if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else if (data_in_valid) begin
                        // back-to-back: next vector replaces the one just finished
                        vec_d = data_in;
                        cnt_d = CNT_ZERO;
                    end else begin
                        cnt_d   = CNT_ZERO;
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Beat select as an AND-OR mux over all slices; cnt_q picks exactly one.
    always_comb begin
        for (int j = 0; j < OUT_NUM; j++) begin
            data_out[j] = '0;
        end
        for (int k = 0; k < BEATS; k++) begin
            for (int j = 0; j < OUT_NUM; j++) begin
                data_out[j] = data_out[j] |
                    (vec_q[k*OUT_NUM + j] & {DATA_WIDTH{cnt_q == CNT_W'(k)}});
            end
        end
    end

    // State, counter and vector registers; reset discards any partial vector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            for (int i = 0; i < IN_NUM; i++) begin
                vec_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
        end
    end

endmodule

// File: tb/tb_unpacked_vector_serializer.sv
module tb_unpacked_vector_serializer;

    logic       clk;
    logic       rst;

    // instance 0: IN_NUM=16, OUT_NUM=4 (four beats per vector)
    logic [7:0] din0 [15:0];
    logic       vin0;
    logic       irdy0;
    logic [7:0] dout0 [3:0];
    logic       vout0;
    logic       ordy0;
    logic [31:0] got0;

    // instance 1: IN_NUM=OUT_NUM=16 (single beat per vector)
    logic [7:0] din1 [15:0];
    logic       vin1;
    logic       irdy1;
    logic [7:0] dout1 [15:0];
    logic       vout1;
    logic       ordy1;
    logic [127:0] got1;

`ifdef SERIALIZER_LAST_EN
    logic       last0;
    logic       last1;
`endif

    int n_total;
    int n_bad;

    unpacked_vector_serializer #(.DATA_WIDTH(8), .IN_NUM(16), .OUT_NUM(4)) u_dut0 (
        .clk(clk), .rst(rst),
        .data_in(din0), .data_in_valid(vin0), .data_in_ready(irdy0),
        .data_out(dout0), .data_out_valid(vout0), .data_out_ready(ordy0)
`ifdef SERIALIZER_LAST_EN
        , .data_out_last(last0)
`endif
    );

    unpacked_vector_serializer #(.DATA_WIDTH(8), .IN_NUM(16), .OUT_NUM(16)) u_dut1 (
        .clk(clk), .rst(rst),
        .data_in(din1), .data_in_valid(vin1), .data_in_ready(irdy1),
        .data_out(dout1), .data_out_valid(vout1), .data_out_ready(ordy1)
`ifdef SERIALIZER_LAST_EN
        , .data_out_last(last1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        got0 = {dout0[3], dout0[2], dout0[1], dout0[0]};
        got1 = '0;
        for (int j = 0; j < 16; j++) got1[8*j +: 8] = dout1[j];
    end

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // beat k of a vector whose element i equals base+i
    function automatic logic [31:0] beat4(input int base, input int k);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = 8'(base + 4*k + j);
        return r;
    endfunction

    function automatic logic [127:0] vec16(input int base);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[8*j +: 8] = 8'(base + j);
        return r;
    endfunction

    // new inputs on the falling edge, then settle before sampling
    task automatic drive0(input logic v, input int base, input logic ordy);
        @(negedge clk);
        vin0 = v;
        for (int i = 0; i < 16; i++) din0[i] = 8'(base + i);
        ordy0 = ordy;
        #1;
    endtask

    task automatic drive1(input logic v, input int base, input logic ordy);
        @(negedge clk);
        vin1 = v;
        for (int i = 0; i < 16; i++) din1[i] = 8'(base + i);
        ordy1 = ordy;
        #1;
    endtask

    logic [7:0]  sb_q [$];
    logic [31:0] exp_beat;
    logic [31:0] prev_beat;
    logic        prev_stall;
    logic        pending;
    int          sent;
    int          rcvd;
    int          cyc;

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b0;
        vin0 = 1'b0; ordy0 = 1'b0;
        vin1 = 1'b0; ordy1 = 1'b0;
        for (int i = 0; i < 16; i++) begin din0[i] = 8'h00; din1[i] = 8'h00; end

        // reset state
        @(negedge clk); #1;
        check_value("rst_in_ready", irdy0, 1'b0);
        check_value("rst_out_valid", vout0, 1'b0);
        check_value("rst_data_out", got0, 32'h0);
        check_value("rst_in_ready_b1", irdy1, 1'b0);
`ifdef SERIALIZER_LAST_EN
        check_value("rst_last", last0, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_value("rel_in_ready", irdy0, 1'b1);
        check_value("rel_out_valid", vout0, 1'b0);

        // single vector, continuous ready
        drive0(1'b1, 0, 1'b1);
        check_value("t1_accept_rdy", irdy0, 1'b1);
        check_value("t1_accept_vld", vout0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive0(1'b0, 0, 1'b1);
            check_value("t1_valid", vout0, 1'b1);
            check_value("t1_beat", got0, beat4(0, k));
            check_value("t1_in_ready", irdy0, (k == 3) ? 1'b1 : 1'b0);
`ifdef SERIALIZER_LAST_EN
            check_value("t1_last", last0, (k == 3) ? 1'b1 : 1'b0);
`endif
        end
        drive0(1'b0, 0, 1'b1);
        check_value("t1_idle_vld", vout0, 1'b0);
        check_value("t1_idle_rdy", irdy0, 1'b1);

        // back-to-back vectors with valid held
        drive0(1'b1, 0, 1'b1);
        check_value("t2_accept", irdy0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            drive0(1'b1, 100, 1'b1);
            check_value("t2_v0_valid", vout0, 1'b1);
            check_value("t2_v0_beat", got0, beat4(0, k));
            check_value("t2_v0_in_ready", irdy0, (k == 3) ? 1'b1 : 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            drive0(1'b0, 100, 1'b1);
            check_value("t2_v1_valid", vout0, 1'b1);
            check_value("t2_v1_beat", got0, beat4(100, k));
        end
        drive0(1'b0, 0, 1'b1);
        check_value("t2_idle_vld", vout0, 1'b0);

        // backpressure on beat 1 for five cycles
        drive0(1'b1, 0, 1'b1);
        drive0(1'b0, 0, 1'b1);
        check_value("t3_beat0", got0, beat4(0, 0));
        for (int s = 0; s < 5; s++) begin
            drive0(1'b1, 200, 1'b0);
            check_value("t3_stall_valid", vout0, 1'b1);
            check_value("t3_stall_beat", got0, beat4(0, 1));
            check_value("t3_stall_in_ready", irdy0, 1'b0);
        end
        drive0(1'b0, 0, 1'b1);
        check_value("t3_release_beat", got0, beat4(0, 1));
        drive0(1'b0, 0, 1'b1);
        check_value("t3_beat2", got0, beat4(0, 2));
        drive0(1'b0, 0, 1'b1);
        check_value("t3_beat3", got0, beat4(0, 3));
        drive0(1'b0, 0, 1'b1);
        check_value("t3_idle_vld", vout0, 1'b0);

        // reset in the middle of a vector
        drive0(1'b1, 64, 1'b1);
        drive0(1'b0, 64, 1'b1);
        check_value("t4_beat0", got0, beat4(64, 0));
        drive0(1'b0, 64, 1'b1);
        check_value("t4_beat1", got0, beat4(64, 1));
        rst = 1'b0;
        #1;
        check_value("t4_rst_valid", vout0, 1'b0);
        check_value("t4_rst_data", got0, 32'h0);
        check_value("t4_rst_in_ready", irdy0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_value("t4_rel_in_ready", irdy0, 1'b1);
        check_value("t4_rel_valid", vout0, 1'b0);
        drive0(1'b1, 80, 1'b1);
        check_value("t4_new_accept", irdy0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            drive0(1'b0, 80, 1'b1);
            check_value("t4_new_beat", got0, beat4(80, k));
        end
        drive0(1'b0, 0, 1'b1);
        check_value("t4_idle_vld", vout0, 1'b0);

        // random valid/ready with scoreboard
        pending = 1'b0; sent = 0; rcvd = 0; cyc = 0; prev_stall = 1'b0; prev_beat = '0;
        while ((sent < 1000 || rcvd < 4000) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (!pending && sent < 1000 && ($urandom % 2) == 1) begin
                for (int i = 0; i < 16; i++) din0[i] = 8'($urandom);
                pending = 1'b1;
            end
            vin0  = pending;
            ordy0 = (($urandom % 2) == 1);
            #1;
            if (prev_stall) begin
                check_value("r_stall_valid", vout0, 1'b1);
                check_value("r_stall_data", got0, prev_beat);
            end
            if (vout0 && ordy0) begin
                if (sb_q.size() < 4) begin
                    check_value("r_sb_depth", sb_q.size(), 4);
                end else begin
                    for (int j = 0; j < 4; j++) exp_beat[8*j +: 8] = sb_q.pop_front();
                    check_value("r_beat", got0, exp_beat);
                end
                rcvd++;
            end
            prev_stall = vout0 && !ordy0;
            prev_beat  = got0;
            if (vin0 && irdy0) begin
                for (int i = 0; i < 16; i++) sb_q.push_back(din0[i]);
                pending = 1'b0;
                sent++;
            end
        end
        check_value("r_beats_seen", rcvd, 4000);
        check_value("r_sb_empty", sb_q.size(), 0);
        drive0(1'b0, 0, 1'b0);

        // single-beat configuration, continuous stream
        for (int t = 0; t < 5; t++) begin
            drive1(1'b1, 10 + 20*t, 1'b1);
            check_value("b1_in_ready", irdy1, 1'b1);
            if (t == 0) begin
                check_value("b1_first_valid", vout1, 1'b0);
            end else begin
                check_value("b1_valid", vout1, 1'b1);
                check_value("b1_data", got1, vec16(10 + 20*(t-1)));
`ifdef SERIALIZER_LAST_EN
                check_value("b1_last", last1, 1'b1);
`endif
            end
        end
        drive1(1'b0, 0, 1'b1);
        check_value("b1_tail_valid", vout1, 1'b1);
        check_value("b1_tail_data", got1, vec16(90));
        drive1(1'b0, 0, 1'b1);
        check_value("b1_idle_valid", vout1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
